// File: rtl/pwm_seq_pkg.sv
// Shared types, channel encodings and saturating level arithmetic for the
// PWM duty sequencer.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } seq_state_t;

  localparam logic [1:0] CH_R  = 2'd0;
  localparam logic [1:0] CH_G  = 2'd1;
  localparam logic [1:0] CH_B  = 2'd2;
  localparam logic [1:0] CH_BZ = 2'd3;

  // Wide enough for duty words up to 16 bits plus one guard bit for saturation.
  localparam int LVL_W = 17;
  typedef logic [LVL_W-1:0] lvl_t;

  function automatic lvl_t sat_add(input lvl_t level, input lvl_t step, input lvl_t dmax);
    lvl_t sum;
    sum = level + step;
    return (sum > dmax) ? dmax : sum;
  endfunction

  function automatic lvl_t sat_sub(input lvl_t level, input lvl_t step);
    return (level > step) ? level - step : '0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks while i_run is
// high; the count is held at zero while i_run is low.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = i_run && (cnt == CW'(PRESCALE - 1));

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                cnt <= '0;
    else if (!i_run || o_tick) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Breathing duty-cycle source: ramps one channel up, holds, ramps down, then
// rotates to the next channel. Define SEQ_BZ_EN to include the buzzer.
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int PRESCALE   = 50000,
  parameter int STEP       = 4,
  parameter int HOLD_TICKS = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              i_enable,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DUTY_W-1:0] o_duty_bz,
  output logic [DUTY_W-1:0] o_duty_r,
  output logic [DUTY_W-1:0] o_duty_g,
  output logic [DUTY_W-1:0] o_duty_b,
  output logic [1:0]        o_chan,
  output logic              o_busy
);

  localparam lvl_t DMAX_L = lvl_t'((1 << DUTY_W) - 1);
  localparam lvl_t STEP_L = lvl_t'(STEP);
  localparam int   HW     = $clog2(HOLD_TICKS + 1);

  function automatic logic [1:0] next_chan(input logic [1:0] c);
`ifdef SEQ_BZ_EN
    return c + 2'd1;
`else
    return (c == CH_B) ? CH_R : c + 2'd1;
`endif
  endfunction

  seq_state_t        state, state_nxt;
  logic [DUTY_W-1:0] level, level_nxt;
  logic [1:0]        chan, chan_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt, hold_inc;
  logic              pending, pending_nxt;
  logic              en_q;
  logic              tick, stall, take_pending, step_tick, publish;
  lvl_t              lvl_calc;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .i_run  (i_enable),
    .o_tick (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the case/if tree can leave a value unassigned and infer a latch.
  always_comb begin
    stall        = o_valid && !i_ready;
    take_pending = pending && !o_valid;
    step_tick    = (tick && !stall) || take_pending;
    state_nxt    = state;
    level_nxt    = level;
    chan_nxt     = chan;
    hold_nxt     = hold_cnt;
    hold_inc     = hold_cnt + HW'(1);
    pending_nxt  = pending;
    publish      = 1'b0;
    lvl_calc     = lvl_t'(level);

    // At most one tick is remembered across a stalled handshake.
    if (take_pending)       pending_nxt = tick;
    else if (tick && stall) pending_nxt = 1'b1;

    if (step_tick) begin
      case (state)
        IDLE: state_nxt = UP;
        UP: begin
          lvl_calc  = sat_add(lvl_t'(level), STEP_L, DMAX_L);
          level_nxt = lvl_calc[DUTY_W-1:0];
          publish   = 1'b1;
          if (lvl_calc == DMAX_L) begin
            state_nxt = HOLD;
            hold_nxt  = '0;
          end
        end
        HOLD: begin
          hold_nxt = hold_inc;
          if (hold_inc == HW'(HOLD_TICKS)) state_nxt = DOWN;
        end
        DOWN: begin
          lvl_calc  = sat_sub(lvl_t'(level), STEP_L);
          level_nxt = lvl_calc[DUTY_W-1:0];
          publish   = 1'b1;
          if (lvl_calc == '0) begin
            chan_nxt  = next_chan(chan);
            state_nxt = UP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Disabling overrides everything, including an unaccepted older set.
    if (!i_enable) begin
      state_nxt   = IDLE;
      level_nxt   = '0;
      chan_nxt    = CH_R;
      hold_nxt    = '0;
      pending_nxt = 1'b0;
      publish     = en_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      level     <= '0;
      chan      <= CH_R;
      hold_cnt  <= '0;
      pending   <= 1'b0;
      en_q      <= 1'b0;
      o_valid   <= 1'b0;
      o_duty_r  <= '0;
      o_duty_g  <= '0;
      o_duty_b  <= '0;
`ifdef SEQ_BZ_EN
      o_duty_bz <= '0;
`endif
      o_chan    <= CH_R;
      o_busy    <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      chan     <= chan_nxt;
      hold_cnt <= hold_nxt;
      pending  <= pending_nxt;
      en_q     <= i_enable;
      o_busy   <= (state_nxt != IDLE);
      if (publish) begin
        o_valid   <= 1'b1;
        o_duty_r  <= (chan_nxt == CH_R)  ? level_nxt : '0;
        o_duty_g  <= (chan_nxt == CH_G)  ? level_nxt : '0;
        o_duty_b  <= (chan_nxt == CH_B)  ? level_nxt : '0;
`ifdef SEQ_BZ_EN
        o_duty_bz <= (chan_nxt == CH_BZ) ? level_nxt : '0;
`endif
        o_chan    <= chan_nxt;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifndef SEQ_BZ_EN
  assign o_duty_bz = '0;
`endif

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed self-checking bench for pwm_duty_sequencer (PRESCALE=4, DUTY_W=4,
// HOLD_TICKS=2; STEP=5 main instance, STEP=4 saturation instance).
module tb_pwm_duty_sequencer;

`ifdef SEQ_BZ_EN
  localparam int AFTER_B = 3;
`else
  localparam int AFTER_B = 0;
`endif

  logic       CLK, RST_n, enable, ready;
  logic       valid, busy, v4, busy4;
  logic [3:0] d_bz, d_r, d_g, d_b, bz4, r4, g4, b4;
  logic [1:0] chan, ch4;

  int tests = 0;
  int fails = 0;
  int n;

  pwm_duty_sequencer #(.DUTY_W(4), .PRESCALE(4), .STEP(5), .HOLD_TICKS(2)) dut (
    .CLK(CLK), .RST_n(RST_n), .i_enable(enable), .i_ready(ready),
    .o_valid(valid), .o_duty_bz(d_bz), .o_duty_r(d_r), .o_duty_g(d_g),
    .o_duty_b(d_b), .o_chan(chan), .o_busy(busy)
  );

  pwm_duty_sequencer #(.DUTY_W(4), .PRESCALE(4), .STEP(4), .HOLD_TICKS(2)) dut_s4 (
    .CLK(CLK), .RST_n(RST_n), .i_enable(enable), .i_ready(ready),
    .o_valid(v4), .o_duty_bz(bz4), .o_duty_r(r4), .o_duty_g(g4),
    .o_duty_b(b4), .o_chan(ch4), .o_busy(busy4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next publish of the STEP=5 instance; cycles counts negedges.
  task automatic wait_pub(output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!valid && cycles < 40);
    check("pub_seen", valid, 1);
  endtask

  task automatic wait_pub4(output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!v4 && cycles < 40);
    check("pub4_seen", v4, 1);
  endtask

  task automatic do_reset();
    RST_n  = 1'b0;
    enable = 1'b0;
    ready  = 1'b1;
    repeat (2) @(negedge CLK);
    RST_n  = 1'b1;
    enable = 1'b1;
  endtask

  int          lvl4_exp [8] = '{4, 8, 12, 15, 11, 7, 3, 0};
  int          gap4_exp [8] = '{8, 4, 4, 4, 12, 4, 4, 4};
  int          k;

  initial begin
    // Reset values.
    RST_n = 1'b0; enable = 1'b0; ready = 1'b1;
    #12;
    check("rst_valid", valid, 0);
    check("rst_duty_r", d_r, 0);
    check("rst_duty_g", d_g, 0);
    check("rst_duty_b", d_b, 0);
    check("rst_duty_bz", d_bz, 0);
    check("rst_chan", chan, 0);
    check("rst_busy", busy, 0);

    // Red ramp/hold/down, then green starts.
    do_reset();
    wait_pub(n); check("up1_gap", n, 8);  check("up1_r", d_r, 5);  check("up1_g", d_g, 0);
    check("up1_chan", chan, 0); check("up1_busy", busy, 1);
    wait_pub(n); check("up2_gap", n, 4);  check("up2_r", d_r, 10);
    wait_pub(n); check("up3_gap", n, 4);  check("up3_r", d_r, 15);
    wait_pub(n); check("dn1_gap", n, 12); check("dn1_r", d_r, 10);
    wait_pub(n); check("dn2_gap", n, 4);  check("dn2_r", d_r, 5);
    wait_pub(n); check("dn3_gap", n, 4);  check("dn3_r", d_r, 0);  check("dn3_chan", chan, 1);
    wait_pub(n); check("g1_gap", n, 4);   check("g1_g", d_g, 5);   check("g1_r", d_r, 0);
    check("g1_chan", chan, 1);

    // Saturation with STEP=4.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_pub4(n);
      check($sformatf("sat_gap%0d", i), n, gap4_exp[i]);
      check($sformatf("sat_r%0d", i), r4, lvl4_exp[i]);
    end

    // Back-pressure during UP.
    do_reset();
    wait_pub(n); check("bp_first_r", d_r, 5);
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check($sformatf("bp_hold_valid%0d", i), valid, 1);
      check($sformatf("bp_hold_r%0d", i), d_r, 5);
    end
    ready = 1'b1;
    @(negedge CLK); check("bp_hs_valid", valid, 0);
    @(negedge CLK); check("bp_pend_valid", valid, 1); check("bp_pend_r", d_r, 10);
    @(negedge CLK); check("bp_once_valid", valid, 0);
    wait_pub(n); check("bp_next_gap", n, 1); check("bp_next_r", d_r, 15);

    // Enable dropped in HOLD.
    do_reset();
    repeat (3) wait_pub(n);
    check("hold_r", d_r, 15);
    @(negedge CLK); check("hold_busy", busy, 1);
    enable = 1'b0;
    @(negedge CLK);
    check("off_valid", valid, 1); check("off_r", d_r, 0); check("off_g", d_g, 0);
    check("off_b", d_b, 0); check("off_bz", d_bz, 0); check("off_chan", chan, 0);
    check("off_busy", busy, 0);
    @(negedge CLK); check("off_valid_clr", valid, 0);
    repeat (10) @(negedge CLK);
    check("off_stay_valid", valid, 0); check("off_stay_busy", busy, 0);

    // Asynchronous reset mid-DOWN, then restart from red.
    do_reset();
    repeat (4) wait_pub(n);
    check("mid_dn_r", d_r, 10);
    #2 RST_n = 1'b0;
    #1;
    check("arst_valid", valid, 0); check("arst_r", d_r, 0);
    check("arst_chan", chan, 0);   check("arst_busy", busy, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    wait_pub(n); check("restart_gap", n, 8); check("restart_r", d_r, 5);
    check("restart_chan", chan, 0);

    // Full rotation R -> G -> B -> next.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      wait_pub(n);
      k = (i + 1) / 6;
      check($sformatf("rot_chan%0d", i), chan, (k < 3) ? k : AFTER_B);
      check($sformatf("rot_bz%0d", i), d_bz, 0);
    end
    wait_pub(n);
    check("rot_after_b_chan", chan, AFTER_B);
`ifdef SEQ_BZ_EN
    check("rot_after_b_bz", d_bz, 5);
`else
    check("rot_after_b_r", d_r, 5);
    check("rot_after_b_bz", d_bz, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
